// File: rtl/sha256_msg_padder_pkg.sv
// Shared definitions for the SHA-256 message padder.
// Holds block geometry, the padding byte, the FSM and pending-block
// encodings, and a helper that slices the 64-bit length field into
// big-endian bytes.
package sha256_msg_padder_pkg;

  localparam int BLK_W         = 512;
  localparam int BYTES_PER_BLK = 64;
  localparam int LEN_LANE      = 56;
  localparam logic [7:0] PAD_BYTE = 8'h80;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_BUILD = 2'd1,
    ST_EMIT  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    PEND_NONE   = 2'd0,
    PEND_LEN    = 2'd1,
    PEND_PADLEN = 2'd2
  } pending_e;

  // Byte k (0 = most significant) of the 64-bit length field, which
  // occupies lanes LEN_LANE+0 .. LEN_LANE+7 of the final block.
  function automatic logic [7:0] len_lane_byte(input logic [63:0] len, input int k);
    return len[63-8*k -: 8];
  endfunction

endpackage

// File: rtl/sha256_msg_padder_if.sv
// Handshake bundle between the host byte stream / block consumer and the
// padder.
//   in_valid/in_ready/in_byte/in_keep/in_last : byte stream into the padder
//   blk_valid/blk_ready/blk_data/blk_first/blk_last : padded 512-bit blocks out
// master: the surrounding environment (drives bytes, accepts blocks)
// slave : the padder itself
interface sha256_msg_padder_if;

  logic                                    in_valid;
  logic                                    in_ready;
  logic [7:0]                              in_byte;
  logic                                    in_keep;
  logic                                    in_last;
  logic                                    blk_valid;
  logic                                    blk_ready;
  logic [sha256_msg_padder_pkg::BLK_W-1:0] blk_data;
  logic                                    blk_first;
  logic                                    blk_last;

  modport master (
    output in_valid, in_byte, in_keep, in_last, blk_ready,
    input  in_ready, blk_valid, blk_data, blk_first, blk_last
  );

  modport slave (
    input  in_valid, in_byte, in_keep, in_last, blk_ready,
    output in_ready, blk_valid, blk_data, blk_first, blk_last
  );

endinterface

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder.
// Collects an arbitrary-length byte stream into a 64-lane register and emits
// padded 512-bit blocks: message bytes, 0x80, zero fill, and the 64-bit
// big-endian message bit length. Lane 0 is blk_data[511:504].
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : sha256_msg_padder_if.slave (byte stream in, padded blocks out)
// Parameter:
//   LEN_W : width of the bit-length counter, zero-extended to 64 bits
module sha256_msg_padder
  import sha256_msg_padder_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input logic                clk,
  input logic                rst_n,
  sha256_msg_padder_if.slave bus
);

  state_e           state_q, state_d;
  pending_e         pending_q, pending_d;
  logic [6:0]       idx_q, idx_d;
  logic [LEN_W-1:0] bitlen_q, bitlen_d;
  logic [7:0]       lanes_q [BYTES_PER_BLK];
  logic [7:0]       lanes_d [BYTES_PER_BLK];
  logic             blk_first_q, blk_first_d;
  logic             blk_last_q, blk_last_d;
  logic             msg_start_q, msg_start_d;
  logic [6:0]       pos;
  logic [63:0]      len64;
  logic [BLK_W-1:0] blk_data_w;

  // Next-state logic. The lane register doubles as the output block: it is
  // only written in FILL and BUILD, so it is naturally frozen while a block
  // waits in EMIT. When a message ends, every lane from the 0x80 position
  // upward is rewritten, so stale bytes from an earlier block never leak
  // into the padding. msg_start_q remembers that the next block emitted is
  // the first of a new message; bitlen is cleared only once the final block
  // has been taken, so a BUILD block can still read the length.
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    idx_d       = idx_q;
    bitlen_d    = bitlen_q;
    lanes_d     = lanes_q;
    blk_first_d = blk_first_q;
    blk_last_d  = blk_last_q;
    msg_start_d = msg_start_q;
    pos         = idx_q + 7'(bus.in_keep);
    len64       = '0;

    unique case (state_q)
      ST_FILL: begin
        if (bus.in_valid) begin
          if (bus.in_keep) begin
            lanes_d[idx_q[5:0]] = bus.in_byte;
            bitlen_d            = bitlen_q + LEN_W'(8);
          end
          len64 = 64'(bitlen_d);
          if (bus.in_last) begin
            state_d     = ST_EMIT;
            idx_d       = '0;
            blk_first_d = msg_start_q;
            msg_start_d = 1'b0;
            if (pos == 7'(BYTES_PER_BLK)) begin
              blk_last_d = 1'b0;
              pending_d  = PEND_PADLEN;
            end else begin
              for (int i = 0; i < BYTES_PER_BLK; i++) begin
                if (7'(i) > pos) lanes_d[i] = 8'h00;
              end
              lanes_d[pos[5:0]] = PAD_BYTE;
              if (pos < 7'(LEN_LANE)) begin
                for (int k = 0; k < 8; k++) begin
                  lanes_d[LEN_LANE+k] = len_lane_byte(len64, k);
                end
                blk_last_d = 1'b1;
                pending_d  = PEND_NONE;
              end else begin
                blk_last_d = 1'b0;
                pending_d  = PEND_LEN;
              end
            end
          end else if (bus.in_keep) begin
            if (pos == 7'(BYTES_PER_BLK)) begin
              state_d     = ST_EMIT;
              idx_d       = '0;
              blk_first_d = msg_start_q;
              msg_start_d = 1'b0;
              blk_last_d  = 1'b0;
              pending_d   = PEND_NONE;
            end else begin
              idx_d = pos;
            end
          end
        end
      end

      ST_EMIT: begin
        if (bus.blk_ready) begin
          blk_first_d = 1'b0;
          blk_last_d  = 1'b0;
          if (pending_q == PEND_NONE) begin
            state_d = ST_FILL;
            idx_d   = '0;
            if (blk_last_q) begin
              bitlen_d    = '0;
              msg_start_d = 1'b1;
            end
          end else begin
            state_d = ST_BUILD;
          end
        end
      end

      ST_BUILD: begin
        len64 = 64'(bitlen_q);
        for (int i = 0; i < BYTES_PER_BLK; i++) begin
          lanes_d[i] = 8'h00;
        end
        if (pending_q == PEND_PADLEN) lanes_d[0] = PAD_BYTE;
        for (int k = 0; k < 8; k++) begin
          lanes_d[LEN_LANE+k] = len_lane_byte(len64, k);
        end
        state_d     = ST_EMIT;
        blk_first_d = 1'b0;
        blk_last_d  = 1'b1;
        pending_d   = PEND_NONE;
      end

      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  // State register. Reset drops any partial message and any held block and
  // arms msg_start so the next block is flagged as the first of a message.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FILL;
      pending_q   <= PEND_NONE;
      idx_q       <= '0;
      bitlen_q    <= '0;
      blk_first_q <= 1'b0;
      blk_last_q  <= 1'b0;
      msg_start_q <= 1'b1;
      for (int i = 0; i < BYTES_PER_BLK; i++) begin
        lanes_q[i] <= 8'h00;
      end
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      idx_q       <= idx_d;
      bitlen_q    <= bitlen_d;
      blk_first_q <= blk_first_d;
      blk_last_q  <= blk_last_d;
      msg_start_q <= msg_start_d;
      lanes_q     <= lanes_d;
    end
  end

  // Pack the lanes big-endian: lane 0 lands in the top byte of the block.
  always_comb begin
    blk_data_w = '0;
    for (int i = 0; i < BYTES_PER_BLK; i++) begin
      blk_data_w[BLK_W-1-8*i -: 8] = lanes_q[i];
    end
  end

  assign bus.in_ready  = (state_q == ST_FILL);
  assign bus.blk_valid = (state_q == ST_EMIT);
  assign bus.blk_data  = blk_data_w;
  assign bus.blk_first = blk_first_q;
  assign bus.blk_last  = blk_last_q;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed testbench for sha256_msg_padder. Each scenario task drives bytes,
// collects blocks and compares them against hand-built expected blocks.
module tb_sha256_msg_padder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  sha256_msg_padder_if bus();

  sha256_msg_padder #(.LEN_W(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  logic [511:0] gotData;
  logic         gotFirst;
  logic         gotLast;
  logic         gotOk;

  // Present one beat and hold it until the padder accepts it (bounded).
  task automatic applyStimulus(input logic [7:0] b, input logic keep, input logic last);
    int n;
    n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    bus.in_keep  = keep;
    bus.in_last  = last;
    while (bus.in_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (bus.in_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("[TB] FAIL beat_timeout: in_ready=%b required 1", bus.in_ready);
    end else begin
      @(posedge clk);
    end
    #1;
    bus.in_valid = 1'b0;
    bus.in_keep  = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Send bytes 0..n-1; in_last on the final one when withLast is set.
  task automatic sendSeq(input int n, input bit withLast);
    for (int i = 0; i < n; i++) begin
      applyStimulus(8'(i), 1'b1, withLast && (i == n - 1));
    end
  endtask

  // Wait (bounded) for a block and take it with a one-cycle blk_ready pulse.
  task automatic takeBlock();
    int n;
    n = 0;
    gotOk = 1'b0;
    @(negedge clk);
    while (bus.blk_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (bus.blk_valid === 1'b1) begin
      gotOk    = 1'b1;
      gotData  = bus.blk_data;
      gotFirst = bus.blk_first;
      gotLast  = bus.blk_last;
      bus.blk_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.blk_ready = 1'b0;
    end
  endtask

  function automatic logic [511:0] seqBlock(input int n);
    logic [511:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[511-8*i -: 8] = 8'(i);
    return r;
  endfunction

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({bus.in_ready, bus.blk_valid, bus.blk_first, bus.blk_last} !== 4'b1000) begin
      failures++;
      $display("[TB] FAIL reset_ctrl: got %b required 1000",
               {bus.in_ready, bus.blk_valid, bus.blk_first, bus.blk_last});
    end
    checks++;
    if (bus.blk_data !== 512'd0) begin
      failures++;
      $display("[TB] FAIL reset_data: got %h required 0", bus.blk_data);
    end
  endtask

  task automatic test_abc(input string tag);
    logic [511:0] exp;
    exp = '0;
    exp[511:480] = 32'h61626380;
    exp[63:0] = 64'h18;
    applyStimulus(8'h61, 1'b1, 1'b0);
    applyStimulus(8'h62, 1'b1, 1'b0);
    applyStimulus(8'h63, 1'b1, 1'b1);
    checks++;
    if ({bus.blk_valid, bus.in_ready} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL %s_latency: valid/ready=%b required 10", tag, {bus.blk_valid, bus.in_ready});
    end
    takeBlock();
    checks++;
    if (gotOk !== 1'b1 || gotData !== exp) begin
      failures++;
      $display("[TB] FAIL %s_data: got %h required %h", tag, gotData, exp);
    end
    checks++;
    if ({gotFirst, gotLast} !== 2'b11) begin
      failures++;
      $display("[TB] FAIL %s_flags: got %b required 11", tag, {gotFirst, gotLast});
    end
  endtask

  task automatic test_55_bytes();
    logic [511:0] exp;
    exp = seqBlock(55);
    exp[71:64] = 8'h80;
    exp[63:0] = 64'h1B8;
    sendSeq(55, 1'b1);
    takeBlock();
    checks++;
    if (gotOk !== 1'b1 || gotData !== exp || {gotFirst, gotLast} !== 2'b11) begin
      failures++;
      $display("[TB] FAIL len55: got %h f/l=%b required %h f/l=11", gotData, {gotFirst, gotLast}, exp);
    end
  endtask

  task automatic collect56(input string tag);
    logic [511:0] expA;
    logic [511:0] expB;
    expA = seqBlock(56);
    expA[63:56] = 8'h80;
    expB = '0;
    expB[63:0] = 64'h1C0;
    takeBlock();
    checks++;
    if (gotOk !== 1'b1 || gotData !== expA || {gotFirst, gotLast} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL %s_blkA: got %h f/l=%b required %h f/l=10", tag, gotData, {gotFirst, gotLast}, expA);
    end
    takeBlock();
    checks++;
    if (gotOk !== 1'b1 || gotData !== expB || {gotFirst, gotLast} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL %s_blkB: got %h f/l=%b required %h f/l=01", tag, gotData, {gotFirst, gotLast}, expB);
    end
  endtask

  task automatic test_56_bytes();
    sendSeq(56, 1'b1);
    collect56("len56");
  endtask

  task automatic test_64_bytes();
    logic [511:0] expA;
    logic [511:0] expB;
    expA = seqBlock(64);
    expB = '0;
    expB[511:504] = 8'h80;
    expB[63:0] = 64'h200;
    sendSeq(64, 1'b1);
    takeBlock();
    checks++;
    if (gotOk !== 1'b1 || gotData !== expA || {gotFirst, gotLast} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL len64_blkA: got %h f/l=%b required %h f/l=10", gotData, {gotFirst, gotLast}, expA);
    end
    takeBlock();
    checks++;
    if (gotOk !== 1'b1 || gotData !== expB || {gotFirst, gotLast} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL len64_blkB: got %h f/l=%b required %h f/l=01", gotData, {gotFirst, gotLast}, expB);
    end
  endtask

  task automatic test_backpressure();
    logic [511:0] expA;
    logic [511:0] expAb;
    int bad;
    expA = seqBlock(56);
    expA[63:56] = 8'h80;
    expAb = '0;
    expAb[511:488] = 24'h616280;
    expAb[63:0] = 64'h10;
    bad = 0;
    sendSeq(56, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_byte  = 8'h61;
    bus.in_keep  = 1'b1;
    bus.in_last  = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.blk_data !== expA || bus.in_ready !== 1'b0 || bus.blk_valid !== 1'b1) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("[TB] FAIL hold_stable: %0d unstable cycles, required 0 (data %h)", bad, bus.blk_data);
    end
    collect56("hold");
    applyStimulus(8'h61, 1'b1, 1'b0);
    applyStimulus(8'h62, 1'b1, 1'b1);
    takeBlock();
    checks++;
    if (gotOk !== 1'b1 || gotData !== expAb || {gotFirst, gotLast} !== 2'b11) begin
      failures++;
      $display("[TB] FAIL hold_ab: got %h f/l=%b required %h f/l=11", gotData, {gotFirst, gotLast}, expAb);
    end
  endtask

  task automatic test_keep_error();
    logic [511:0] exp;
    exp = '0;
    exp[511:488] = 24'h616280;
    exp[63:0] = 64'h10;
    applyStimulus(8'h61, 1'b1, 1'b0);
    applyStimulus(8'hEE, 1'b0, 1'b0);
    applyStimulus(8'h62, 1'b1, 1'b1);
    takeBlock();
    checks++;
    if (gotOk !== 1'b1 || gotData !== exp || {gotFirst, gotLast} !== 2'b11) begin
      failures++;
      $display("[TB] FAIL keep0_ignored: got %h f/l=%b required %h f/l=11", gotData, {gotFirst, gotLast}, exp);
    end
  endtask

  task automatic test_mid_reset();
    sendSeq(30, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.in_ready, bus.blk_valid, bus.blk_first, bus.blk_last} !== 4'b1000 || bus.blk_data !== 512'd0) begin
      failures++;
      $display("[TB] FAIL midreset_outputs: ctrl=%b data=%h required 1000 and 0",
               {bus.in_ready, bus.blk_valid, bus.blk_first, bus.blk_last}, bus.blk_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    test_abc("after_reset");
  endtask

  task automatic test_empty();
    logic [511:0] exp;
    exp = '0;
    exp[511:504] = 8'h80;
    applyStimulus(8'h00, 1'b0, 1'b1);
    takeBlock();
    checks++;
    if (gotOk !== 1'b1 || gotData !== exp || {gotFirst, gotLast} !== 2'b11) begin
      failures++;
      $display("[TB] FAIL empty_msg: got %h f/l=%b required %h f/l=11", gotData, {gotFirst, gotLast}, exp);
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_byte   = 8'h00;
    bus.in_keep   = 1'b0;
    bus.in_last   = 1'b0;
    bus.blk_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_abc("abc");
    test_55_bytes();
    test_56_bytes();
    test_64_bytes();
    test_backpressure();
    test_keep_error();
    test_mid_reset();
    test_empty();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
